// File: rtl/aes_pkg.sv
// Shared constants, state encoding and byte-lane helper for the AES block packer.
package aes_pkg;

   localparam int unsigned AES_BLOCK_BYTES = 16;
   localparam int unsigned AES_BLOCK_W     = AES_BLOCK_BYTES * 8;
   localparam int unsigned AES_CNT_W       = 5;

   typedef enum logic [1:0] {
      FILL = 2'd0,
      OUT  = 2'd1,
      PAD  = 2'd2
   } aes_state_e;

   // Byte k of a block lives at [127-8k -: 8]; this returns its low bit index.
   function automatic int unsigned lane_lo(input logic [3:0] k);
      return (AES_BLOCK_BYTES - 1 - 32'(k)) * 8;
   endfunction

endpackage

// File: rtl/aes_pad_gen.sv
// Fills every lane at or beyond n with the pad byte.
// AES_PKCS7_PAD_EN selects PKCS#7 pad bytes (16-n); otherwise lanes are zeroed.
module aes_pad_gen
   import aes_pkg::*;
(
   input  logic [127:0] blk_i,
   input  logic [4:0]   n_i,
   output logic [127:0] blk_o
);

   logic [7:0] pad_byte;

   always_comb begin
`ifdef AES_PKCS7_PAD_EN
      pad_byte = 8'(5'(AES_BLOCK_BYTES) - n_i);
`else
      pad_byte = 8'h00;
`endif
      blk_o = blk_i;
      for (int k = 0; k < int'(AES_BLOCK_BYTES); k++) begin
         if (5'(k) >= n_i) begin
            blk_o[lane_lo(4'(k)) +: 8] = pad_byte;
         end
      end
   end

endmodule

// File: rtl/aes_block_packer.sv
// Packs a valid/ready byte stream into padded 128-bit blocks for the AES core.
// Build option AES_PKCS7_PAD_EN enables PKCS#7 padding and the extra pad block.
module aes_block_packer
   import aes_pkg::*;
#(
   parameter int unsigned BLOCK_BYTES = 16
)
(
   input  logic         clk,
   input  logic         rst,
   input  logic [7:0]   s_data,
   input  logic         s_valid,
   input  logic         s_last,
   output logic         s_ready,
   output logic [127:0] m_block,
   output logic         m_valid,
   output logic         m_last,
   output logic [4:0]   m_count,
   input  logic         m_ready
);

   if (BLOCK_BYTES != AES_BLOCK_BYTES) begin : g_bad_block_bytes
      $error("aes_block_packer: BLOCK_BYTES must be 16");
   end

   aes_state_e     state_q, state_d;
   logic [3:0]     cnt_q, cnt_d;
   logic [127:0]   data_q, data_d;
   logic [127:0]   m_block_q, m_block_d;
   logic           m_valid_q, m_valid_d;
   logic           m_last_q, m_last_d;
   logic [4:0]     m_count_q, m_count_d;
   logic           s_ready_q, s_ready_d;
`ifdef AES_PKCS7_PAD_EN
   logic           pad_pend_q, pad_pend_d;
`endif

   logic [127:0]   data_wr;
   logic [127:0]   padded;
   logic [4:0]     fill_n;
   logic           byte_acc;
   logic           blk_done;

   // Working buffer with the incoming byte dropped into lane cnt.
   always_comb begin
      data_wr = data_q;
      data_wr[lane_lo(cnt_q) +: 8] = s_data;
      fill_n  = 5'(cnt_q) + 5'd1;
   end

   aes_pad_gen u_pad_gen (
      .blk_i (data_wr),
      .n_i   (fill_n),
      .blk_o (padded)
   );

   assign byte_acc = s_valid && s_ready_q;
   assign blk_done = (cnt_q == 4'(AES_BLOCK_BYTES - 1)) || s_last;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      data_d    = data_q;
      m_block_d = m_block_q;
      m_valid_d = m_valid_q;
      m_last_d  = m_last_q;
      m_count_d = m_count_q;
`ifdef AES_PKCS7_PAD_EN
      pad_pend_d = pad_pend_q;
`endif
      case (state_q)
         FILL: begin
            if (byte_acc) begin
               data_d = data_wr;
               cnt_d  = cnt_q + 4'd1;
               if (blk_done) begin
                  state_d   = OUT;
                  cnt_d     = 4'd0;
                  m_block_d = padded;
                  m_count_d = fill_n;
                  m_valid_d = 1'b1;
`ifdef AES_PKCS7_PAD_EN
                  // A message ending on a full block defers m_last to the pad block.
                  m_last_d   = s_last && (cnt_q != 4'(AES_BLOCK_BYTES - 1));
                  pad_pend_d = s_last && (cnt_q == 4'(AES_BLOCK_BYTES - 1));
`else
                  m_last_d = s_last;
`endif
               end
            end
         end
         OUT: begin
            if (m_ready) begin
               cnt_d     = 4'd0;
               state_d   = FILL;
               m_valid_d = 1'b0;
`ifdef AES_PKCS7_PAD_EN
               if (pad_pend_q) begin
                  state_d    = PAD;
                  m_block_d  = {AES_BLOCK_BYTES{8'h10}};
                  m_count_d  = 5'd0;
                  m_last_d   = 1'b1;
                  m_valid_d  = 1'b1;
                  pad_pend_d = 1'b0;
               end
`endif
            end
         end
`ifdef AES_PKCS7_PAD_EN
         PAD: begin
            if (m_ready) begin
               state_d   = FILL;
               m_valid_d = 1'b0;
            end
         end
`endif
         default: begin
            state_d   = FILL;
            m_valid_d = 1'b0;
         end
      endcase
      s_ready_d = (state_d == FILL);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= FILL;
         cnt_q     <= 4'd0;
         data_q    <= '0;
         m_block_q <= '0;
         m_valid_q <= 1'b0;
         m_last_q  <= 1'b0;
         m_count_q <= 5'd0;
         s_ready_q <= 1'b0;
`ifdef AES_PKCS7_PAD_EN
         pad_pend_q <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         data_q    <= data_d;
         m_block_q <= m_block_d;
         m_valid_q <= m_valid_d;
         m_last_q  <= m_last_d;
         m_count_q <= m_count_d;
         s_ready_q <= s_ready_d;
`ifdef AES_PKCS7_PAD_EN
         pad_pend_q <= pad_pend_d;
`endif
      end
   end

   assign s_ready = s_ready_q;
   assign m_block = m_block_q;
   assign m_valid = m_valid_q;
   assign m_last  = m_last_q;
   assign m_count = m_count_q;

endmodule

// File: tb/tb_aes_block_packer.sv
// Bench for aes_block_packer: directed and random messages against a block-level model.
// Expected padding follows AES_PKCS7_PAD_EN when it is defined for the build.
module tb_aes_block_packer;

   typedef struct packed {
      logic [127:0] blk;
      logic [4:0]   cnt;
      logic         last;
   } blk_t;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [7:0]   s_data = 8'h00;
   logic         s_valid = 1'b0;
   logic         s_last = 1'b0;
   logic         s_ready;
   logic [127:0] m_block;
   logic         m_valid;
   logic         m_last;
   logic [4:0]   m_count;
   logic         m_ready = 1'b0;

   logic         rdy_rand = 1'b0;
   logic         rdy_force = 1'b1;

   int n_chk = 0;
   int n_pass = 0;

   logic [7:0] tx_q[$];
   blk_t       exp_q[$];
   blk_t       obs_q[$];

   aes_block_packer #(.BLOCK_BYTES(16)) dut (
      .clk     (clk),
      .rst     (rst),
      .s_data  (s_data),
      .s_valid (s_valid),
      .s_last  (s_last),
      .s_ready (s_ready),
      .m_block (m_block),
      .m_valid (m_valid),
      .m_last  (m_last),
      .m_count (m_count),
      .m_ready (m_ready)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      #1;
      m_ready = rdy_rand ? 1'($urandom_range(1)) : rdy_force;
   end

   // Record every block the packer hands off.
   always @(negedge clk) begin
      if (!rst && m_valid && m_ready)
         obs_q.push_back('{blk: m_block, cnt: m_count, last: m_last});
   end

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   // Reference: cut the whole message into 16-byte chunks and pad the tail.
   task automatic build_expected();
      int   n;
      int   k;
      bit   fin;
      blk_t e;
      n = tx_q.size();
      for (int b = 0; b * 16 < n; b++) begin
         k = (n - b * 16 > 16) ? 16 : n - b * 16;
         e.blk = '0;
         for (int i = 0; i < 16; i++) begin
            if (i < k) e.blk[127 - 8 * i -: 8] = tx_q[b * 16 + i];
`ifdef AES_PKCS7_PAD_EN
            else e.blk[127 - 8 * i -: 8] = 8'(16 - k);
`endif
         end
         fin    = (b * 16 + k == n);
         e.cnt  = 5'(k);
         e.last = fin;
`ifdef AES_PKCS7_PAD_EN
         if (fin && k == 16) e.last = 1'b0;
`endif
         exp_q.push_back(e);
`ifdef AES_PKCS7_PAD_EN
         if (fin && k == 16) exp_q.push_back('{blk: {16{8'h10}}, cnt: 5'd0, last: 1'b1});
`endif
      end
   endtask

   task automatic send_bytes(input bit last_flag, input int gap_pct);
      int idx = 0;
      int guard = 0;
      while (idx < tx_q.size()) begin
         @(posedge clk);
         #1;
         s_valid = ($urandom_range(99) >= gap_pct);
         if (s_valid) begin
            s_data = tx_q[idx];
            s_last = last_flag && (idx == tx_q.size() - 1);
         end else begin
            s_data = 8'($urandom);
            s_last = 1'($urandom_range(1));
         end
         @(negedge clk);
         if (s_valid && s_ready) idx++;
         guard++;
         if (guard > 4000) begin
            chk("send_timeout", 128'(idx), 128'(tx_q.size()));
            break;
         end
      end
      @(posedge clk);
      #1;
      s_valid = 1'b0;
      s_last  = 1'b0;
   endtask

   task automatic drain_and_compare(input string tag);
      int guard = 0;
      while (obs_q.size() < exp_q.size() && guard < 3000) begin
         @(negedge clk);
         guard++;
      end
      repeat (20) @(negedge clk);
      chk({tag, ".nblk"}, 128'(obs_q.size()), 128'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
         chk($sformatf("%s.blk%0d", tag, i), obs_q[i].blk, exp_q[i].blk);
         chk($sformatf("%s.cnt%0d", tag, i), 128'(obs_q[i].cnt), 128'(exp_q[i].cnt));
         chk($sformatf("%s.last%0d", tag, i), 128'(obs_q[i].last), 128'(exp_q[i].last));
      end
      obs_q.delete();
      exp_q.delete();
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, ".s_ready"}, 128'(s_ready), 128'(0));
      chk({tag, ".m_valid"}, 128'(m_valid), 128'(0));
      chk({tag, ".m_last"},  128'(m_last),  128'(0));
      chk({tag, ".m_count"}, 128'(m_count), 128'(0));
      chk({tag, ".m_block"}, m_block, 128'(0));
   endtask

   initial begin
      logic [127:0] blk0;
      int           guard;
      int           len;

      // Reset values, then s_ready rises after release.
      #12;
      check_reset_outputs("rst0");
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("rst0.s_ready_after", 128'(s_ready), 128'(1));

      // 16 bytes 00..0F ending the message, downstream always ready.
      rdy_rand = 1'b0;
      rdy_force = 1'b1;
      tx_q.delete();
      for (int i = 0; i < 16; i++) tx_q.push_back(8'(i));
      build_expected();
      send_bytes(1'b1, 0);
      drain_and_compare("full16");

      // Five byte message AA..EE.
      tx_q = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
      build_expected();
      send_bytes(1'b1, 0);
      drain_and_compare("five");

      // Single byte message.
      tx_q = '{8'h7E};
      build_expected();
      send_bytes(1'b1, 0);
      drain_and_compare("one");

      // 32 bytes with the first block held off for 10 cycles.
      rdy_force = 1'b0;
      @(negedge clk);
      tx_q.delete();
      for (int i = 0; i < 32; i++) tx_q.push_back(8'($urandom));
      build_expected();
      fork
         send_bytes(1'b1, 0);
         begin
            guard = 0;
            while (!m_valid && guard < 500) begin
               @(negedge clk);
               guard++;
            end
            chk("stall.valid_seen", 128'(m_valid), 128'(1));
            blk0 = m_block;
            for (int c = 0; c < 10; c++) begin
               @(negedge clk);
               chk($sformatf("stall.hold%0d", c), m_block, blk0);
               chk($sformatf("stall.sready%0d", c), 128'(s_ready), 128'(0));
            end
            rdy_force = 1'b1;
            @(posedge clk);
            @(posedge clk);
            @(negedge clk);
            chk("stall.sready_after", 128'(s_ready), 128'(1));
         end
      join
      drain_and_compare("stall32");

      // Partial message cut by an asynchronous reset, then a fresh message.
      tx_q.delete();
      for (int i = 0; i < 7; i++) tx_q.push_back(8'hC0 + 8'(i));
      send_bytes(1'b0, 0);
      #2;
      rst = 1'b1;
      #1;
      check_reset_outputs("midrst");
      repeat (2) @(negedge clk);
      rst = 1'b0;
      obs_q.delete();
      tx_q.delete();
      for (int i = 0; i < 16; i++) tx_q.push_back(8'h50 + 8'(i));
      build_expected();
      send_bytes(1'b1, 0);
      drain_and_compare("fresh16");

      // Empty message: nothing should appear.
      tx_q.delete();
      build_expected();
      drain_and_compare("empty");

      // Random lengths, random gaps and back-pressure.
      rdy_rand = 1'b1;
      for (int m = 0; m < 12; m++) begin
         len = (m == 0) ? 16 : (m == 1) ? 17 : int'($urandom_range(40, 1));
         tx_q.delete();
         for (int i = 0; i < len; i++) tx_q.push_back(8'($urandom));
         build_expected();
         send_bytes(1'b1, 30);
         drain_and_compare($sformatf("rand%0d", m));
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
